// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction memory server.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    READY = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Wide enough for any supported word width; users slice the low DATA_W bits.
  localparam int MAX_DATA_W = 1024;
  localparam logic [MAX_DATA_W-1:0] NOP_WORD = '0;

  localparam int ERR_RD_RANGE   = 0;
  localparam int ERR_RD_OVERLAP = 1;
  localparam int ERR_WR_REJECT  = 2;
  localparam int ERR_PARITY     = 3;

endpackage

// File: rtl/inst_mem_server_inst_ram.sv
// Simple dual-port program RAM with a registered read (latency 1).
// INST_PARITY_EN adds one even-parity bit per stored word, checked on read.
module inst_ram
  import inst_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_par_err
);

`ifdef INST_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int WORD_W = DATA_W + PAR_W;

  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] rd_word_reg;
  logic [WORD_W-1:0] wr_word;

`ifdef INST_PARITY_EN
  // Stored parity makes the XOR over the whole word zero when intact.
  assign wr_word    = {^wr_data, wr_data};
  assign rd_par_err = ^rd_word_reg;
`else
  assign wr_word    = wr_data;
  assign rd_par_err = 1'b0;
`endif

  assign rd_data = rd_word_reg[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_word_reg <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/inst_mem_server.sv
// Instruction store: host loads and commits a program, streamer reads it back
// with fixed latency RD_LAT. Optional parity checking via INST_PARITY_EN.
module inst_mem_server
  import inst_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 128,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_wr_en,
  input  logic [DATA_W-1:0] host_wr_data,
  input  logic              host_commit,
  input  logic              host_clear,
  output logic              CAN_READ_INST,
  input  logic              FINISH,
  input  logic              RD_START,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_DONE,
  output logic [ADDR_W:0]   inst_count,
  output logic [3:0]        err_flags,
  output logic              par_err
);

  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W:0]   inst_count_reg;
  logic [3:0]        err_reg, err_set;
  logic [RD_LAT-1:0] vld_reg, vld_next;
  logic              oor_reg;
  logic [DATA_W-1:0] rd_hold_reg;

  logic              wr_fire, rd_accept, rd_in_flight, rd_oor, rd_done;
  logic [DATA_W-1:0] ram_data, stage0_data, last_data;
  logic              ram_perr, stage0_perr, last_perr;

  assign rd_in_flight = |vld_reg;
  assign rd_oor       = {1'b0, RD_ADDR} >= inst_count_reg;
  assign rd_done      = vld_reg[RD_LAT-1];

  always_comb begin
    state_next = state_reg;
    wr_fire    = 1'b0;
    rd_accept  = 1'b0;
    err_set    = '0;
    if (host_clear) begin
      state_next = LOAD;
    end else begin
      case (state_reg)
        LOAD: begin
          if (host_wr_en) begin
            if (inst_count_reg == FULL_COUNT) err_set[ERR_WR_REJECT] = 1'b1;
            else                              wr_fire = 1'b1;
          end
          if (host_commit && inst_count_reg != '0) state_next = READY;
        end
        READY: begin
          if (host_wr_en) err_set[ERR_WR_REJECT] = 1'b1;
          // FINISH beats a same-cycle read request.
          if (FINISH) begin
            state_next = DONE;
          end else if (RD_START) begin
            if (rd_in_flight) begin
              err_set[ERR_RD_OVERLAP] = 1'b1;
            end else begin
              rd_accept             = 1'b1;
              err_set[ERR_RD_RANGE] = rd_oor;
            end
          end
        end
        DONE: begin
          if (host_wr_en)  err_set[ERR_WR_REJECT] = 1'b1;
          if (host_commit) state_next = READY;
        end
        default: state_next = LOAD;
      endcase
      err_set[ERR_PARITY] = par_err;
    end
  end

  always_comb begin
    vld_next    = '0;
    vld_next[0] = rd_accept;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_next[i] = vld_reg[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= LOAD;
      wr_ptr_reg     <= '0;
      inst_count_reg <= '0;
      err_reg        <= '0;
      vld_reg        <= '0;
      rd_hold_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (host_clear) begin
        wr_ptr_reg     <= '0;
        inst_count_reg <= '0;
        err_reg        <= '0;
        vld_reg        <= '0;
      end else begin
        if (wr_fire) begin
          wr_ptr_reg     <= wr_ptr_reg + 1'b1;
          inst_count_reg <= inst_count_reg + 1'b1;
        end
        err_reg <= err_reg | err_set;
        vld_reg <= vld_next;
      end
      if (rd_done) rd_hold_reg <= last_data;
    end
  end

  // Out-of-range flag travels alongside the RAM's own read register.
  always_ff @(posedge clk) begin
    if (rd_accept) oor_reg <= rd_oor;
  end

  inst_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk        (clk),
    .wr_en      (wr_fire),
    .wr_addr    (wr_ptr_reg),
    .wr_data    (host_wr_data),
    .rd_en      (rd_accept),
    .rd_addr    (RD_ADDR),
    .rd_data    (ram_data),
    .rd_par_err (ram_perr)
  );

  assign stage0_data = oor_reg ? NOP_WORD[DATA_W-1:0] : ram_data;
  assign stage0_perr = ram_perr & ~oor_reg;

  generate
    if (RD_LAT == 1) begin : g_direct
      assign last_data = stage0_data;
      assign last_perr = stage0_perr;
    end else begin : g_pipe
      logic [DATA_W-1:0] dat_reg [RD_LAT-1];
      logic [RD_LAT-2:0] perr_reg;
      always_ff @(posedge clk) begin
        dat_reg[0]  <= stage0_data;
        perr_reg[0] <= stage0_perr;
        for (int i = 1; i < RD_LAT - 1; i++) begin
          dat_reg[i]  <= dat_reg[i-1];
          perr_reg[i] <= perr_reg[i-1];
        end
      end
      assign last_data = dat_reg[RD_LAT-2];
      assign last_perr = perr_reg[RD_LAT-2];
    end
  endgenerate

  assign CAN_READ_INST = (state_reg == READY);
  assign RD_DONE       = rd_done;
  assign RD_DATA       = rd_done ? last_data : rd_hold_reg;
  assign inst_count    = inst_count_reg;
  assign err_flags     = err_reg;
  assign par_err       = rd_done & last_perr;

endmodule
